// File: rtl/tmds_decoder_if.sv
// Symbol/decoded-output bundle for one TMDS receive channel.
// The deserializer side (master) supplies symbols; the decoder (slave) returns decoded fields and bitslip.
interface tmds_decoder_if;
  logic [9:0] sym_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       locked;
  logic       bitslip;

  modport master (
    output sym_in,
    input  data_out, ctrl_out, de_out, locked, bitslip
  );

  modport slave (
    input  sym_in,
    output data_out, ctrl_out, de_out, locked, bitslip
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: word alignment via bitslip on blanking-token runs,
// then 10b symbol decode to pixel data or control bits.
module tmds_decoder #(
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int CTRL_RUN       = 16,
  parameter int SLIP_WAIT      = 4
) (
  input logic           clk_pix,
  input logic           rst_pix_n,
  tmds_decoder_if.slave tmds
);

  localparam int TW = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int RW = $clog2(CTRL_RUN) + 1;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [9:0]    sym_q;
  logic          is_ctrl;
  logic [1:0]    ctrl_val;
  logic [7:0]    d_word;
  logic [7:0]    decoded;
  logic [RW-1:0] run_cnt;
  logic          run_hit;
  logic [TW-1:0] timer;
  logic          expire;
  logic          slip_set;
  logic          bitslip_q;
  logic [7:0]    data_q;
  logic [1:0]    ctrl_q;
  logic          de_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sym_q <= '0;
    end else begin
      sym_q <= tmds.sym_in;
    end
  end

  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (sym_q)
      10'b1101010100: ctrl_val = 2'b00;
      10'b0010101011: ctrl_val = 2'b01;
      10'b0101010100: ctrl_val = 2'b10;
      10'b1010101011: ctrl_val = 2'b11;
      default:        is_ctrl  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR chain of the encoder.
  always_comb begin
    d_word     = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    decoded    = '0;
    decoded[0] = d_word[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = sym_q[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
    end
  end

  assign run_hit = (state != ST_SLIP_WAIT) && is_ctrl && (run_cnt == RW'(CTRL_RUN - 1));
  assign expire  = (timer == TW'(SEARCH_TIMEOUT - 1));

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      run_cnt <= '0;
    end else if ((state == ST_SLIP_WAIT) || !is_ctrl) begin
      run_cnt <= '0;
    end else if (run_cnt != RW'(CTRL_RUN)) begin
      run_cnt <= run_cnt + RW'(1);
    end
  end

  // The timer doubles as the settle counter while waiting after a slip.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      timer <= '0;
    end else if (run_hit || (state_next != state)) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state <= ST_SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    slip_set   = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (run_hit) begin
          state_next = ST_LOCKED;
        end else if (expire) begin
          state_next = ST_SLIP_WAIT;
          slip_set   = 1'b1;
        end
      end
      ST_SLIP_WAIT: begin
        if (timer == TW'(SLIP_WAIT)) begin
          state_next = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (expire && !run_hit) begin
          state_next = ST_SEARCH;
        end
      end
      default: state_next = ST_SEARCH;
    endcase
  end

  // Outputs are gated by the state being entered so they agree with locked.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      data_q    <= '0;
      ctrl_q    <= '0;
      de_q      <= 1'b0;
      bitslip_q <= 1'b0;
    end else begin
      bitslip_q <= slip_set;
      if (state_next != ST_LOCKED) begin
        data_q <= '0;
        ctrl_q <= '0;
        de_q   <= 1'b0;
      end else if (is_ctrl) begin
        ctrl_q <= ctrl_val;
        de_q   <= 1'b0;
      end else begin
        data_q <= decoded;
        de_q   <= 1'b1;
      end
    end
  end

  assign tmds.data_out = data_q;
  assign tmds.ctrl_out = ctrl_q;
  assign tmds.de_out   = de_q;
  assign tmds.locked   = (state == ST_LOCKED);
  assign tmds.bitslip  = bitslip_q;

endmodule
